// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 SEQ register file with decode read and writeback commit
module decode_writeback #(
  parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0200,
  parameter int          NREG     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] dbg_val
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [63:0] regs_q [NREG];
  logic [63:0] regs_d [NREG];
  logic [3:0]  src_a, src_b, dst_e, dst_m;

  // Decode: derive source and destination register IDs from the instruction
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      4'h2: begin
        src_a = rA;
        if (cnd) dst_e = rB;
      end
      4'h3: dst_e = rB;
      4'h4: begin
        src_a = rA;
        src_b = rB;
      end
      4'h5: begin
        src_b = rB;
        dst_m = rA;
      end
      4'h6: begin
        src_a = rA;
        src_b = rB;
        dst_e = rB;
      end
      4'h8: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      4'h9: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      4'hA: begin
        src_a = rA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      4'hB: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = rA;
      end
      default: ;
    endcase
  end

  // Read ports: pre-commit contents, ID 0xF (or any unmatched ID) reads zero
  always_comb begin
    valA    = 64'h0;
    valB    = 64'h0;
    dbg_val = 64'h0;
    for (int i = 0; i < NREG; i++) begin
      if (src_a == 4'(i))   valA    = regs_q[i];
      if (src_b == 4'(i))   valB    = regs_q[i];
      if (dbg_sel == 4'(i)) dbg_val = regs_q[i];
    end
  end

  // Writeback next state: valM is applied after valE so it wins on popq %rsp
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (wb_en && dst_e == 4'(i)) regs_d[i] = valE;
      if (wb_en && dst_m == 4'(i)) regs_d[i] = valM;
    end
  end

  // Register state: reset overrides any in-flight commit
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (rst) regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      else     regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_decode_writeback.sv
// tb/tb_decode_writeback.sv - scoreboard bench for decode_writeback
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, rA, rB, dbg_sel;
  logic        cnd, wb_en;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB, dbg_val;

  typedef struct {
    string       name;
    int          port;
    logic [63:0] exp;
  } chk_t;

  chk_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   stim_done = 1'b0;

  localparam int P_A   = 0;
  localparam int P_B   = 1;
  localparam int P_DBG = 2;

  decode_writeback dut (
    .clk     (clk),
    .rst     (rst),
    .icode   (icode),
    .rA      (rA),
    .rB      (rB),
    .cnd     (cnd),
    .valE    (valE),
    .valM    (valM),
    .wb_en   (wb_en),
    .dbg_sel (dbg_sel),
    .valA    (valA),
    .valB    (valB),
    .dbg_val (dbg_val)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string name, input int port, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.port = port;
    c.exp  = exp;
    sb.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    cnd = 1'b0; wb_en = 1'b0; valE = '0; valM = '0;
  endtask

  task automatic op(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                    input logic c, input logic [63:0] e, input logic [63:0] m, input logic w);
    icode = ic; rA = ra; rB = rb; cnd = c; valE = e; valM = m; wb_en = w;
  endtask

  task automatic peek(input string name, input logic [3:0] sel, input logic [63:0] exp);
    dbg_sel = sel;
    expect_out(name, P_DBG, exp);
    step();
  endtask

  // Monitor: outputs are settled mid-cycle, so compare everything queued at the falling edge
  initial begin
    chk_t        c;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        c = sb.pop_front();
        act = (c.port == P_A) ? valA : (c.port == P_B) ? valB : dbg_val;
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    idle();
    dbg_sel = 4'hF;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // reset contents
    for (int s = 0; s < 16; s++) begin
      peek($sformatf("reset_reg%0d", s), 4'(s), (s == 4) ? 64'h200 : 64'h0);
    end

    // irmovq $0xDEADBEEF, %rdx
    op(4'h3, 4'hF, 4'h2, 1'b0, 64'hDEAD_BEEF, 64'h0, 1'b1);
    expect_out("irmov_valA", P_A, 64'h0);
    expect_out("irmov_valB", P_B, 64'h0);
    step(); idle();
    peek("irmov_reg2", 4'h2, 64'hDEAD_BEEF);

    // cmovXX not taken, then taken
    op(4'h2, 4'h2, 4'h3, 1'b0, 64'h5, 64'h0, 1'b1);
    expect_out("cmov0_valA", P_A, 64'hDEAD_BEEF);
    step(); idle();
    peek("cmov0_reg3", 4'h3, 64'h0);
    op(4'h2, 4'h2, 4'h3, 1'b1, 64'h5, 64'h0, 1'b1);
    expect_out("cmov1_valA", P_A, 64'hDEAD_BEEF);
    step(); idle();
    peek("cmov1_reg3", 4'h3, 64'h5);

    // popq %rsp: valM wins over valE
    op(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'h1234, 1'b1);
    expect_out("popq_valA", P_A, 64'h200);
    expect_out("popq_valB", P_B, 64'h200);
    step(); idle();
    peek("popq_reg4", 4'h4, 64'h1234);

    // OPq with commit disabled, then enabled
    op(4'h6, 4'h3, 4'h1, 1'b0, 64'h7, 64'h0, 1'b0);
    expect_out("opq_off_valA", P_A, 64'h5);
    expect_out("opq_off_valB", P_B, 64'h0);
    step(); idle();
    peek("opq_off_reg1", 4'h1, 64'h0);
    op(4'h6, 4'h3, 4'h1, 1'b0, 64'h7, 64'h0, 1'b1);
    step(); idle();
    peek("opq_on_reg1", 4'h1, 64'h7);

    // pushq %rdx: srcB is %rsp, dstE is %rsp
    op(4'hA, 4'h2, 4'hF, 1'b0, 64'h1224, 64'h0, 1'b1);
    expect_out("pushq_valA", P_A, 64'hDEAD_BEEF);
    expect_out("pushq_valB", P_B, 64'h1234);
    step(); idle();
    peek("pushq_reg4", 4'h4, 64'h1224);

    // mrmovq: dstM = rA, srcB = rB
    op(4'h5, 4'h6, 4'h2, 1'b0, 64'h99, 64'hABC, 1'b1);
    expect_out("mrmov_valB", P_B, 64'hDEAD_BEEF);
    step(); idle();
    peek("mrmov_reg6", 4'h6, 64'hABC);

    // unknown decode inputs with commit disabled
    icode = 4'bxxxx; rA = 4'bxxxx; rB = 4'bxxxx; wb_en = 1'b0;
    step(); idle();
    peek("xsafe_reg2", 4'h2, 64'hDEAD_BEEF);

    // reset overrides an in-flight commit
    op(4'h3, 4'hF, 4'h5, 1'b0, 64'h9, 64'h0, 1'b1);
    rst = 1'b1;
    step(); idle();
    peek("rstmid_reg5", 4'h5, 64'h0);
    peek("rstmid_reg4", 4'h4, 64'h200);
    peek("rstmid_reg2", 4'h2, 64'h0);
    peek("rstmid_reg6", 4'h6, 64'h0);

    step();
    stim_done = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
